// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the parity helper shared by the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_START  = 4'd7;

  // XOR of up to 9 data bits (zero-extend narrower words) folded with the odd select.
  function automatic logic calc_parity(input logic [8:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous idle-high inputs (rxd, cts);
// resets to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability chain, synchronous active-low reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery with a
// valid/ready output holding one frame plus parity, framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state_r,   state_nx;
  logic [3:0]           os_cnt_r,  os_cnt_nx;
  logic [3:0]           bit_cnt_r, bit_cnt_nx;
  logic [DATA_BITS-1:0] shift_r,   shift_nx;
  logic                 armed_r,   armed_nx;
  logic                 par_bad_r, par_bad_nx;
  logic                 fbad_r,    fbad_nx;
  logic                 stop_hit_s;
  logic                 done_r;
  logic                 busy_r;
  logic                 accept_s;
  logic                 deliver_s;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 overrun_r;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Next-state and datapath decode; everything holds unless sample_tick is high.
  always_comb begin
    state_nx   = state_r;
    os_cnt_nx  = os_cnt_r;
    bit_cnt_nx = bit_cnt_r;
    shift_nx   = shift_r;
    armed_nx   = armed_r;
    par_bad_nx = par_bad_r;
    fbad_nx    = fbad_r;
    stop_hit_s = 1'b0;
    if (sample_tick) begin
      if (rxd_s) begin
        armed_nx = 1'b1;
      end else begin
        armed_nx = armed_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (!rxd_s && armed_r) begin
            state_nx   = ST_START;
            os_cnt_nx  = 4'd0;
            par_bad_nx = 1'b0;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_START: begin
          if (os_cnt_r == MID_START) begin
            // A high line at mid start bit is a glitch, not a frame.
            if (rxd_s) begin
              state_nx = ST_IDLE;
            end else begin
              state_nx   = ST_DATA;
              os_cnt_nx  = 4'd0;
              bit_cnt_nx = 4'd0;
            end
          end else begin
            os_cnt_nx = os_cnt_r + 4'd1;
          end
        end
        ST_DATA: begin
          os_cnt_nx = os_cnt_r + 4'd1;
          if (os_cnt_r == LAST_TICK) begin
            // Shift in at the top; after DATA_BITS samples the first bit sits at the LSB.
            shift_nx   = {rxd_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_nx = bit_cnt_r + 4'd1;
            if (bit_cnt_r == LAST_BIT) begin
              state_nx = PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              state_nx = ST_DATA;
            end
          end else begin
            state_nx = ST_DATA;
          end
        end
        ST_PARITY: begin
          os_cnt_nx = os_cnt_r + 4'd1;
          if (os_cnt_r == LAST_TICK) begin
            par_bad_nx = calc_parity(9'(shift_r), PARITY_ODD) ^ rxd_s;
            state_nx   = ST_STOP;
          end else begin
            state_nx = ST_PARITY;
          end
        end
        ST_STOP: begin
          os_cnt_nx = os_cnt_r + 4'd1;
          if (os_cnt_r == LAST_TICK) begin
            fbad_nx    = ~rxd_s;
            stop_hit_s = 1'b1;
            state_nx   = ST_IDLE;
            // Disarm on a low stop bit so a held break cannot start another frame.
            if (!rxd_s) begin
              armed_nx = 1'b0;
            end else begin
              armed_nx = 1'b1;
            end
          end else begin
            state_nx = ST_STOP;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end else begin
      stop_hit_s = 1'b0;
    end
  end

  // Receiver state, counters and per-frame capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      os_cnt_r  <= 4'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      armed_r   <= 1'b0;
      par_bad_r <= 1'b0;
      fbad_r    <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      os_cnt_r  <= os_cnt_nx;
      bit_cnt_r <= bit_cnt_nx;
      shift_r   <= shift_nx;
      armed_r   <= armed_nx;
      par_bad_r <= par_bad_nx;
      fbad_r    <= fbad_nx;
      done_r    <= stop_hit_s;
      busy_r    <= (state_nx != ST_IDLE);
    end
  end

  assign accept_s  = rx_valid_r && rx_ready;
  assign deliver_s = done_r && (!rx_valid_r || rx_ready);

  // Output holding register and handshake; runs every clk regardless of ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_r    <= {DATA_BITS{1'b0}};
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (deliver_s) begin
        rx_data_r    <= shift_r;
        parity_err_r <= par_bad_r;
        frame_err_r  <= fbad_r;
        rx_valid_r   <= 1'b1;
      end else if (accept_s) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
      // A finished frame with nowhere to go is dropped and flagged.
      if (done_r && rx_valid_r && !rx_ready) begin
        overrun_r <= 1'b1;
      end else if (accept_s) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule
